serial_complementer: RTL and testbench

Bit-serial, word-framed complement engine: accepts a WIDTH-bit word LSB-first, one bit per valid cycle, and emits the one's or two's complement of that word bit-serially with one cycle of latency. It also presents the assembled result in parallel with an overflow flag. It supersedes the unframed single-mode serial one's-complement FSM in the FSM library. It sits between a serial bit source and either a serial sink or a parallel consumer.

---
 rtl/serial_comp_pkg.sv | 18 +
 rtl/serial_comp_deser.sv | 45 ++++
 rtl/serial_complementer.sv | 80 ++++++++
 tb/tb_serial_complementer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_comp_pkg.sv
// Shared types and constants for the bit-serial complement engine.
// Pure declarations; no logic, no latency, no flow control.
package serial_comp_pkg;

  typedef enum logic {
    S_PASS = 1'b0,
    S_INV  = 1'b1
  } state_t;

  localparam logic MODE_ONES = 1'b0;
  localparam logic MODE_TWOS = 1'b1;

  // Two's complement copies bits up to and including the first 1, so it starts in PASS.
  function automatic state_t first_state(input logic m);
    return (m == MODE_TWOS) ? S_PASS : S_INV;
  endfunction

endpackage

// File: rtl/serial_comp_deser.sv
// Collects result bits into a word and publishes it with a one-cycle strobe.
// Latency 1 cycle from the last bit; no backpressure, every accepted bit is stored.
module serial_comp_deser #(
  parameter int WIDTH = 8,
  parameter int IW    = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_vld,
  input  logic [IW-1:0]    bit_idx,
  input  logic             bit_dat,
  input  logic             bit_last,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] merged;

  // The last bit never lands in the shadow; it is merged straight into word_out.
  always_comb begin
    merged          = shadow;
    merged[bit_idx] = bit_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (bit_vld) begin
        if (bit_last) begin
          word_out   <= merged;
          word_valid <= 1'b1;
          shadow     <= '0;
        end else begin
          shadow <= merged;
        end
      end
    end
  end

endmodule

// File: rtl/serial_complementer.sv
// Word-framed bit-serial one's/two's complementer with parallel result and overflow flag.
// Latency 1 cycle per bit; no backpressure, source may insert idle gaps at will.
module serial_complementer
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_data,
  input  logic             mode,
  output logic             out_valid,
  output logic             out_data,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             ovf,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [CW-1:0] bit_cnt;
  state_t        state;
  logic          mode_q;

  logic          first_bit;
  logic          last_bit;
  logic          mode_eff;
  state_t        state_eff;
  logic          res_bit;

  // Bit 0 re-derives everything from the live mode input; later bits use the latched copy.
  always_comb begin
    first_bit = (bit_cnt == '0);
    last_bit  = (bit_cnt == CW'(WIDTH - 1));
    mode_eff  = first_bit ? mode : mode_q;
    state_eff = first_bit ? first_state(mode) : state;
    res_bit   = (state_eff == S_PASS) ? in_data : ~in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      state     <= S_PASS;
      mode_q    <= MODE_ONES;
      out_valid <= 1'b0;
      out_data  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      ovf       <= 1'b0;
      if (in_valid) begin
        out_data <= res_bit;
        bit_cnt  <= last_bit ? '0 : bit_cnt + CW'(1);
        mode_q   <= mode_eff;
        state    <= (state_eff == S_PASS && in_data) ? S_INV : state_eff;
        // MSB still copied through means every lower bit was 0: the most-negative value.
        ovf      <= last_bit & (mode_eff == MODE_TWOS) & in_data & (state_eff == S_PASS);
      end
    end
  end

  assign busy = (bit_cnt != '0);

  serial_comp_deser #(
    .WIDTH (WIDTH),
    .IW    (CW)
  ) u_deser (
    .clk        (clk),
    .rst        (rst),
    .bit_vld    (in_valid),
    .bit_idx    (bit_cnt),
    .bit_dat    (res_bit),
    .bit_last   (last_bit),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

endmodule

// File: tb/tb_serial_complementer.sv
// Directed vector bench for serial_complementer at WIDTH=8.
module tb_serial_complementer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_data;
  logic       mode;
  logic       out_valid;
  logic       out_data;
  logic [7:0] word_out;
  logic       word_valid;
  logic       ovf;
  logic       busy;

  serial_complementer #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .word_out   (word_out),
    .word_valid (word_valid),
    .ovf        (ovf),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       m;
    logic [7:0] din;
    logic [7:0] exp_w;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl[6];

  int         nchk = 0;
  int         nerr = 0;
  int         cyc  = 0;
  int         sidx = 0;
  int         ov_cnt = 0;
  logic [7:0] sacc = '0;
  logic [7:0] wq[$];
  logic       oq[$];
  logic [7:0] sq[$];
  int         cq[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Collects the serial stream and every parallel word strobe.
  always @(negedge clk) begin
    if (word_valid) begin
      nchk++;
      if (!(out_valid && sidx == 7)) begin
        nerr++;
        $display("FAIL wv_align: out_valid=%0b serial_idx=%0d, required out_valid=1 serial_idx=7", out_valid, sidx);
      end
      wq.push_back(word_out);
      oq.push_back(ovf);
      cq.push_back(cyc);
    end
    if (out_valid) begin
      ov_cnt++;
      sacc[sidx] = out_data;
      if (sidx == 7) begin
        sq.push_back(sacc);
        sidx = 0;
      end else begin
        sidx++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic m);
    @(negedge clk);
    in_valid = v;
    in_data  = d;
    mode     = m;
  endtask

  task automatic send_word(input logic m, input logic [7:0] w);
    for (int i = 0; i < 8; i++) drive(1'b1, w[i], m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_q();
    wq.delete();
    oq.delete();
    sq.delete();
    cq.delete();
    ov_cnt = 0;
  endtask

  task automatic check_word(input string name, input int idx, input logic [7:0] exp_w, input logic exp_o);
    if (idx >= wq.size() || idx >= sq.size()) begin
      nchk++;
      nerr++;
      $display("FAIL %s: word %0d missing, got %0d words, required at least %0d", name, idx, wq.size(), idx + 1);
    end else begin
      check({name, "_word"},   {24'd0, wq[idx]}, {24'd0, exp_w});
      check({name, "_serial"}, {24'd0, sq[idx]}, {24'd0, exp_w});
      check({name, "_ovf"},    {31'd0, oq[idx]}, {31'd0, exp_o});
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_out_valid"},  {31'd0, out_valid},  32'd0);
    check({name, "_out_data"},   {31'd0, out_data},   32'd0);
    check({name, "_word_out"},   {24'd0, word_out},   32'd0);
    check({name, "_word_valid"}, {31'd0, word_valid}, 32'd0);
    check({name, "_ovf"},        {31'd0, ovf},        32'd0);
    check({name, "_busy"},       {31'd0, busy},       32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 8'hA5, 8'h5A, 1'b0};
    tbl[1] = '{1'b1, 8'h0C, 8'hF4, 1'b0};
    tbl[2] = '{1'b1, 8'h01, 8'hFF, 1'b0};
    tbl[3] = '{1'b1, 8'h00, 8'h00, 1'b0};
    tbl[4] = '{1'b1, 8'h80, 8'h80, 1'b1};
    tbl[5] = '{1'b1, 8'h7F, 8'h81, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = 1'b0; mode = 1'b0;
    idle(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    idle(2);

    // Table words run back-to-back at full rate.
    clear_q();
    foreach (tbl[i]) send_word(tbl[i].m, tbl[i].din);
    idle(3);
    check("tbl_count", wq.size(), 32'd6);
    foreach (tbl[i]) check_word($sformatf("tbl%0d", i), i, tbl[i].exp_w, tbl[i].exp_ovf);
    for (int i = 1; i < cq.size(); i++) check($sformatf("tbl_spacing%0d", i), cq[i] - cq[i-1], 32'd8);

    // One's mode 0x3C with idle gaps after bits 2 and 5.
    clear_q();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, i[0] ? 1'b0 : 1'b0, 1'b0);
      in_data = (8'h3C >> i) & 8'h01;
      if (i == 2) begin
        drive(1'b0, 1'b0, 1'b0);
        check("gap_latency_valid", {31'd0, out_valid}, 32'd1);
        check("gap_latency_data",  {31'd0, out_data},  32'd0);
        drive(1'b0, 1'b0, 1'b0);
        check("gap1_out_valid", {31'd0, out_valid}, 32'd0);
        check("gap1_busy",      {31'd0, busy},      32'd1);
        drive(1'b0, 1'b0, 1'b0);
        check("gap1_busy_late", {31'd0, busy},      32'd1);
      end
      if (i == 5) begin
        drive(1'b0, 1'b0, 1'b0);
        check("gap2_busy", {31'd0, busy}, 32'd1);
      end
    end
    idle(3);
    check("gap_count", wq.size(), 32'd1);
    check_word("gap", 0, 8'hC3, 1'b0);
    check("gap_out_valid_pulses", ov_cnt, 32'd8);
    check("gap_idle_busy", {31'd0, busy}, 32'd0);

    // Mode latched at bit 0; later changes ignored.
    clear_q();
    for (int i = 0; i < 8; i++) drive(1'b1, (8'h06 >> i) & 8'h01, (i < 3) ? 1'b1 : 1'b0);
    idle(3);
    check("modechg_count", wq.size(), 32'd1);
    check_word("modechg", 0, 8'hFA, 1'b0);

    // Reset mid-word, coinciding with a valid bit.
    clear_q();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_data = 1'b1;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst = 1'b0; in_valid = 1'b0;
    sidx = 0;
    idle(2);
    check("midreset_no_word", wq.size(), 32'd0);
    clear_q();
    send_word(1'b0, 8'h0F);
    idle(3);
    check("post_reset_count", wq.size(), 32'd1);
    check_word("post_reset", 0, 8'hF0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
